// File: rtl/logic_unit_arb_pkg.sv
// Shared encodings and sizes for the arbitrated 16-bit logic unit.
package logic_unit_arb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 3;

  // Operation select encodings.
  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_ANDN = 2'b11
  } op_e;

  // Occupancy FSM encodings.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : logic_unit_arb_pkg

// File: rtl/logic_unit_arb_logic16.sv
// Combinational 16-bit bitwise unit: AND / OR / XOR / ANDN (in1 & ~in2).
module logic16
  import logic_unit_arb_pkg::*;
(
  input  logic [15:0] in1_i,
  input  logic [15:0] in2_i,
  input  logic [1:0]  op_i,
  output logic [15:0] out_o
);

  logic [15:0] and_s;
  logic [15:0] or_s;
  logic [15:0] xor_s;
  logic [15:0] andn_s;

  assign and_s  = in1_i & in2_i;
  assign or_s   = in1_i | in2_i;
  assign xor_s  = in1_i ^ in2_i;
  assign andn_s = in1_i & ~in2_i;

  // Select the bitwise result for the requested operation.
  always_comb begin
    out_o = 16'h0000;
    case (op_e'(op_i))
      OP_AND:  out_o = and_s;
      OP_OR:   out_o = or_s;
      OP_XOR:  out_o = xor_s;
      OP_ANDN: out_o = andn_s;
      default: out_o = 16'h0000;
    endcase
  end

endmodule : logic16

// File: rtl/logic_unit_arb.sv
// Round-robin shared logic unit: two requesters, valid/ready accept, one
// tagged result pulse LAT cycles after each accept.
module logic_unit_arb
  import logic_unit_arb_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned OPW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [OPW-1:0] req0_op,
  input  logic [15:0]    req0_a,
  input  logic [15:0]    req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [OPW-1:0] req1_op,
  input  logic [15:0]    req1_a,
  input  logic [15:0]    req1_b,
  output logic           req1_ready,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [15:0]    rsp_data,
  output logic           busy
);

  if ((LAT < 1) || (LAT > 8) || (OPW != 2)) begin : g_param_check
    $error("logic_unit_arb: LAT must be 1..8 and OPW must be 2");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(LAT - 1);
  localparam bit               LAT_IS_ONE = (LAT == 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prio_q, prio_d;
  logic [OPW-1:0]      op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic                id_q;
  logic                rsp_valid_q, rsp_id_q, busy_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                can_accept_s, grant_s, accept_s;
  logic [OPW-1:0]      sel_op_s, src_op_s;
  logic [DATA_W-1:0]   sel_a_s, sel_b_s, src_a_s, src_b_s, result_s;
  logic                src_id_s;

  // Arbitration: pick a requester by round-robin priority and form readies.
  always_comb begin
    can_accept_s = (state_q == IDLE) || (state_q == DONE);
    if (req0_valid && req1_valid) begin
      grant_s = prio_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s   = can_accept_s && (req0_valid || req1_valid);
    req0_ready = can_accept_s && req0_valid && !grant_s;
    req1_ready = can_accept_s && req1_valid && grant_s;
    prio_d     = accept_s ? !grant_s : prio_q;
  end

  // Operand mux for the granted requester.
  always_comb begin
    if (grant_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  // With LAT==1 the result is due on the accept edge itself, so the unit
  // must see the live granted operands instead of the latched copies.
  always_comb begin
    if (LAT_IS_ONE) begin
      src_op_s = sel_op_s;
      src_a_s  = sel_a_s;
      src_b_s  = sel_b_s;
      src_id_s = grant_s;
    end else begin
      src_op_s = op_q;
      src_a_s  = a_q;
      src_b_s  = b_q;
      src_id_s = id_q;
    end
  end

  logic16 u_logic16 (
    .in1_i (src_a_s),
    .in2_i (src_b_s),
    .op_i  (src_op_s),
    .out_o (result_s)
  );

  // Next-state logic: occupancy countdown from accept to the DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          if (LAT_IS_ONE) begin
            state_d = DONE;
            cnt_d   = 3'd0;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      end
      BUSY: begin
        if (cnt_q == 3'd1) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, operand capture and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      prio_q      <= 1'b0;
      op_q        <= '0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      if (accept_s) begin
        op_q <= sel_op_s;
        a_q  <= sel_a_s;
        b_q  <= sel_b_s;
        id_q <= grant_s;
      end
      rsp_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      if (state_d == DONE) begin
        rsp_data_q <= result_s;
        rsp_id_q   <= src_id_s;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule : logic_unit_arb

// File: tb/tb_logic_unit_arb.sv
// Randomized bench: three instances (LAT = 1, 2, 4) driven by independent
// random requesters and checked every cycle against a timeline model.
module tb_logic_unit_arb;

  localparam int NI     = 3;
  localparam int CYCLES = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0][1:0]       vld;
  logic [NI-1:0][1:0][1:0]  opv;
  logic [NI-1:0][1:0][15:0] av, bv;
  wire  [NI-1:0][1:0]       rdy;
  wire  [NI-1:0]            rv, rid, bsy;
  wire  [NI-1:0][15:0]      rd;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic_unit_arb #(.LAT(1 << g), .OPW(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (vld[g][0]),
      .req0_op    (opv[g][0]),
      .req0_a     (av[g][0]),
      .req0_b     (bv[g][0]),
      .req0_ready (rdy[g][0]),
      .req1_valid (vld[g][1]),
      .req1_op    (opv[g][1]),
      .req1_a     (av[g][1]),
      .req1_b     (bv[g][1]),
      .req1_ready (rdy[g][1]),
      .rsp_valid  (rv[g]),
      .rsp_id     (rid[g]),
      .rsp_data   (rd[g]),
      .busy       (bsy[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  // Model: each instance is a timeline of accepts; the result of the accept
  // at cycle a is shown at a+L, and the unit is free again at a+L.
  int          acc_t  [NI];
  bit          infl   [NI];
  bit          prio   [NI];
  logic [15:0] pend_d [NI];
  bit          pend_id[NI];
  logic [15:0] ld     [NI];
  bit          lid    [NI];
  logic [NI-1:0][1:0] acc;

  initial begin
    int t;
    vld = '0; opv = '0; av = '0; bv = '0; acc = '0;
    for (int k = 0; k < NI; k++) begin
      infl[k] = 1'b0; prio[k] = 1'b0; ld[k] = 16'h0000; lid[k] = 1'b0;
      acc_t[k] = 0; pend_d[k] = 16'h0000; pend_id[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with no requests.
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check_val($sformatf("L%0d reset busy", 1 << k), 32'(bsy[k]), 32'd0);
      check_val($sformatf("L%0d reset rsp_valid", 1 << k), 32'(rv[k]), 32'd0);
      check_val($sformatf("L%0d reset rsp_data", 1 << k), 32'(rd[k]), 32'd0);
      check_val($sformatf("L%0d reset ready", 1 << k), 32'(rdy[k]), 32'd0);
    end
    @(posedge clk);
    #1;

    t = 0;
    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        int  L;
        bit  done_now, bsy_e, can, g, e0, e1;
        L        = 1 << k;
        done_now = infl[k] && (t == acc_t[k] + L);
        bsy_e    = infl[k] && (t > acc_t[k]) && (t <= acc_t[k] + L);
        can      = !infl[k] || (t >= acc_t[k] + L);
        g        = (vld[k][0] && vld[k][1]) ? prio[k] : vld[k][1];
        e0       = can && vld[k][0] && !g;
        e1       = can && vld[k][1] && g;
        if (done_now) begin
          ld[k]  = pend_d[k];
          lid[k] = pend_id[k];
        end
        check_val($sformatf("L%0d ready0", L), 32'(rdy[k][0]), 32'(e0));
        check_val($sformatf("L%0d ready1", L), 32'(rdy[k][1]), 32'(e1));
        check_val($sformatf("L%0d rsp_valid", L), 32'(rv[k]), 32'(done_now));
        check_val($sformatf("L%0d rsp_id", L), 32'(rid[k]), 32'(lid[k]));
        check_val($sformatf("L%0d rsp_data", L), 32'(rd[k]), 32'(ld[k]));
        check_val($sformatf("L%0d busy", L), 32'(bsy[k]), 32'(bsy_e));
        acc[k][0] = e0;
        acc[k][1] = e1;
        if (rst) begin
          infl[k] = 1'b0; prio[k] = 1'b0; ld[k] = 16'h0000; lid[k] = 1'b0;
        end else if (e0 || e1) begin
          acc_t[k]   = t;
          infl[k]    = 1'b1;
          pend_d[k]  = ref_op(opv[k][g], av[k][g], bv[k][g]);
          pend_id[k] = g;
          prio[k]    = !g;
        end
      end
      @(posedge clk);
      #1;
      t++;
      // Requesters: hold until accepted, then maybe continue; idle inputs churn.
      for (int k = 0; k < NI; k++) begin
        for (int r = 0; r < 2; r++) begin
          bit taken;
          taken = acc[k][r] && !rst;
          if (taken) vld[k][r] = ($urandom_range(0, 2) != 0);
          else if (!vld[k][r]) vld[k][r] = 1'($urandom_range(0, 1));
          if (!vld[k][r] || taken) begin
            opv[k][r] = 2'($urandom_range(0, 3));
            av[k][r]  = 16'($urandom);
            bv[k][r]  = 16'($urandom);
          end
        end
      end
      rst = ($urandom_range(0, 149) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_logic_unit_arb

// File: doc/logic_unit_arb.md
Name: logic_unit_arb

Overview:
- Shares one 16-bit bitwise logic unit (AND/OR/XOR/ANDN) between two requesters, e.g. the execute stage and the address/flag path.
- Round-robin arbitration with a valid/ready request handshake.
- Operands are latched on grant. The unit is modelled as occupied for LAT cycles.
- Returns one tagged result pulse per accepted request.

Parameters:
- LAT, 2, cycles from accept to result pulse; legal range 1..8.
- OPW, 2, width of the op select field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b)
- req0_a  in  16  operand A
- req0_b  in  16  operand B
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same as requester 0, for requester 1
- rsp_valid  out  1  result pulse
- rsp_id  out  1  requester that owns the result
- rsp_data  out  16  result
- busy  out  1  unit occupied (state != IDLE)

Behaviour:
- One clock: clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, cnt=0, prio=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, both ready outputs 0.
- Reset mid-operation abandons the in-flight op and no rsp_valid follows.
- FSM states: IDLE, BUSY, DONE.
- can_accept = (state==IDLE) or (state==DONE).
- Grant:
  - Only requester 0 valid → grant 0. Only requester 1 valid → grant 1.
  - Both valid → grant prio.
  - reqN_ready = can_accept & grantN. Ready is combinational from state, prio and valids.
- Handshake:
  - Accept = valid & ready in the same cycle.
  - Requester holds valid, op, a and b stable until accepted.
  - Valid must not depend on ready.
  - Operands, op and id are registered on accept; later input changes have no effect.
- prio update: on any accept, prio <= ~granted_id. With no accept, prio holds.
- Transitions:
  - IDLE: accept → BUSY with cnt=LAT-1; if LAT==1, go to DONE instead.
  - BUSY: cnt decrements each cycle; at cnt==1, next state DONE.
  - DONE: rsp_valid=1 for this cycle only, with rsp_id and rsp_data. Accept in this cycle → BUSY or DONE as from IDLE. No accept → IDLE.
- Latency: accept in cycle c → rsp_valid in cycle c+LAT, exactly one cycle wide.
- Throughput: one op per LAT cycles, with back-to-back accept in the DONE cycle. LAT=1 gives one op per cycle.
- rsp_data and rsp_id hold their last value when rsp_valid=0. Consumers must sample only on rsp_valid.
- No response backpressure: requesters must sink rsp_valid unconditionally.
- Result is computed from the latched operands using the team's gate-level cells. Result is registered into rsp_data on entry to DONE.
- Counter is 3 bits. A LAT outside 1..8 is a static elaboration error.

Decomposition:
- Shared package holds:
  - op encodings OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ANDN=2'b11
  - FSM state encodings IDLE=2'b00, BUSY=2'b01, DONE=2'b10
- One sub-module, logic16: combinational 16-bit op-select unit (in1, in2, op → out) built from the existing gate primitives and 16-bit bitwise cells.
- The arbiter, FSM, counter and operand/result registers live in logic_unit_arb, using the team's dff cells.

Test Plan:
- Reset then idle: rst high 2 cycles, no valids → busy=0, rsp_valid=0, both readies 0, rsp_data=0x0000.
- Single op, LAT=2: req0 OR, a=0x00F0, b=0x0F00, accept at c0 → rsp_valid only at c0+2, rsp_id=0, rsp_data=0x0FF0.
- Contention and fairness:
  - Both valid from reset: req0 XOR 0xFFFF^0x00FF, req1 ANDN 0xFFFF&~0x00FF.
  - req0 granted first → result 0xFF00, id 0.
  - req1 accepted in that DONE cycle → result 0xFF00, id 1.
  - Grants alternate thereafter.
- Back-to-back, LAT=1: req1 valid 4 cycles with AND a=0xA5A5, b=0x0FF0 → ready every cycle, rsp_valid 4 consecutive cycles, each rsp_data=0x05A0, rsp_id=1.
- Operand capture: req0 accepted with a=0x1234, b=0x0000 OR; inputs change to 0xFFFF the next cycle → rsp_data=0x1234.
- Reset mid-op: accept at c0 (LAT=4), rst at c2 → no rsp_valid at c4, state=IDLE, prio=0.
